// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit memory port.
// Provides the RV32I funct3 size/sign codes, the port FSM state enum,
// the captured-request struct, byte-enable generation, store-data lane
// replication and the legality (size/alignment) check.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam int NUM_LANES = 4;   // byte lanes per bus word

   typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RD, RESP} lsu_state_t;

   typedef struct packed {
      logic       we;
      logic [2:0] funct3;
      logic [1:0] off;
   } lsu_req_t;

   // funct3[1:0] carries the access size for both signed and unsigned loads.
   function automatic logic [NUM_LANES-1:0] be_gen(input logic [2:0] funct3,
                                                   input logic [1:0] off);
      case (funct3[1:0])
         2'b00:   be_gen = 4'b0001 << off;
         2'b01:   be_gen = 4'b0011 << off;
         default: be_gen = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] wdata_rep(input logic [2:0]  funct3,
                                             input logic [31:0] wdata);
      case (funct3[1:0])
         2'b00:   wdata_rep = {4{wdata[7:0]}};
         2'b01:   wdata_rep = {2{wdata[15:0]}};
         default: wdata_rep = wdata;
      endcase
   endfunction

   // Unsigned variants exist only for loads; halves need even, words
   // need 4-byte aligned addresses.
   function automatic logic req_legal(input logic       we,
                                      input logic [2:0] funct3,
                                      input logic [1:0] off);
      case (funct3)
         F3_B:    req_legal = 1'b1;
         F3_H:    req_legal = ~off[0];
         F3_W:    req_legal = (off == 2'b00);
         F3_BU:   req_legal = ~we;
         F3_HU:   req_legal = ~we & ~off[0];
         default: req_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem_port_if.sv
// Word-addressed data memory bus with request/grant and read-valid
// handshakes.
//   master (LSU side): drives mem_req, mem_we, mem_addr, mem_be, mem_wdata;
//                      receives mem_gnt, mem_rvalid, mem_rdata.
//   slave  (memory side): the mirror image.
interface lsu_mem_port_if #(parameter int ADDR_W = 32);
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-3:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;

   modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                   input  mem_gnt, mem_rvalid, mem_rdata);
   modport slave  (input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                   output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the addressed byte/half-word lane out of a
// bus read word and sign- or zero-extends it to 32 bits.
//   mem_rdata in  32  raw read word
//   off       in   2  byte offset (addr[1:0])
//   funct3    in   3  RV32I load size/sign
//   data      out 32  extended load result
module lsu_load_align
   import lsu_pkg::*;
(
   input  logic [31:0] mem_rdata,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [NUM_LANES-1:0][7:0] lanes;
   logic [7:0]                b;
   logic [15:0]               h;

   always_comb begin
      lanes = mem_rdata;
      b     = lanes[off];
      h     = off[1] ? {lanes[3], lanes[2]} : {lanes[1], lanes[0]};
      case (funct3)
         F3_B:    data = {{24{b[7]}}, b};
         F3_BU:   data = {24'b0, b};
         F3_H:    data = {{16{h[15]}}, h};
         F3_HU:   data = {16'b0, h};
         default: data = mem_rdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store unit memory port. Accepts one byte/half/word access at a time
// from the memory stage, issues it on the word-addressed bus, and returns
// a one-cycle response with the extended load data (DataRd) or an error.
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/we/funct3/addr/wdata   core request (addr is ALURes, wdata rs2)
//   req_ready             high while idle (request accepted this cycle)
//   stall                 hold the memory stage until the response
//   rsp_valid/rdata/err   one-cycle response; rdata is 0 unless a load hit
//   mem                   bus master port (req/gnt, rvalid/rdata)
module lsu_mem_port
   import lsu_pkg::*;
#(
   parameter int TIMEOUT_CYC = 16,   // minimum 2
   parameter int ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              req_ready,
   output logic              stall,
   output logic              rsp_valid,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   lsu_mem_port_if.master    mem
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC);

   lsu_state_t        state_q, state_d;
   lsu_req_t          req_q;
   logic [ADDR_W-3:0] addr_q;
   logic [3:0]        be_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;
   logic              err_q;
   logic [CNT_W-1:0]  cnt_q;

   logic              legal;
   logic              expired;
   logic [31:0]       ld_data;

   assign legal   = req_legal(req_we, req_funct3, req_addr[1:0]);
   assign expired = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   lsu_load_align u_align (
      .mem_rdata (mem.mem_rdata),
      .off       (req_q.off),
      .funct3    (req_q.funct3),
      .data      (ld_data)
   );

   // Next state. The awaited event is tested before expiry so that a
   // grant/rvalid landing on the last counted cycle still completes.
   // mem_rvalid is only looked at in WAIT_RD, so one coincident with the
   // grant is ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (req_valid) state_d = legal ? WAIT_GNT : RESP;
         WAIT_GNT: if (mem.mem_gnt) state_d = req_q.we ? RESP : WAIT_RD;
                   else if (expired) state_d = RESP;
         WAIT_RD:  if (mem.mem_rvalid || expired) state_d = RESP;
         RESP:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= '0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         // Any state change restarts the count, which covers entry into
         // both wait states.
         if (state_d != state_q)
            cnt_q <= '0;
         else if (state_q == WAIT_GNT || state_q == WAIT_RD)
            cnt_q <= cnt_q + 1'b1;

         case (state_q)
            IDLE: if (req_valid) begin
               req_q   <= '{we: req_we, funct3: req_funct3, off: req_addr[1:0]};
               addr_q  <= req_addr[ADDR_W-1:2];
               be_q    <= be_gen(req_funct3, req_addr[1:0]);
               wdata_q <= wdata_rep(req_funct3, req_wdata);
               err_q   <= ~legal;
               rdata_q <= '0;
            end
            WAIT_GNT: if (!mem.mem_gnt && expired) err_q <= 1'b1;
            WAIT_RD:  if (mem.mem_rvalid) rdata_q <= ld_data;
                      else if (expired)   err_q   <= 1'b1;
            default: ;
         endcase
      end
   end

   assign req_ready = (state_q == IDLE);
   assign rsp_valid = (state_q == RESP);
   assign rsp_err   = rsp_valid & err_q;
   assign rsp_rdata = rsp_valid ? rdata_q : 32'b0;

   // Bus fields come straight from the capture registers, so they are
   // stable for the whole grant wait.
   assign mem.mem_req   = (state_q == WAIT_GNT);
   assign mem.mem_we    = mem.mem_req & req_q.we;
   assign mem.mem_be    = mem.mem_req ? be_q : 4'b0;
   assign mem.mem_addr  = addr_q;
   assign mem.mem_wdata = wdata_q;

   // Only a legal request stalls in its accept cycle; an illegal one
   // resolves in the following RESP cycle, where stall is already low.
   assign stall = req_valid & ((state_q != IDLE) | legal) & ~rsp_valid;

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;
   import lsu_pkg::*;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic        req_ready, stall, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   logic [31:0] ref_rdata, ref_data;
   logic [1:0]  ref_off;
   logic [2:0]  ref_f3;

   lsu_mem_port_if #(.ADDR_W(32)) mem_if ();

   lsu_mem_port #(.TIMEOUT_CYC(TO), .ADDR_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .stall      (stall),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .mem        (mem_if.master)
   );

   lsu_load_align u_ref (
      .mem_rdata (ref_rdata),
      .off       (ref_off),
      .funct3    (ref_f3),
      .data      (ref_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      string       nm;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   int   rsp_seen = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard monitor: every response pops one expectation.
   always @(negedge clk) begin
      if (rsp_valid) begin
         rsp_seen++;
         if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk({e.nm, ".err"},   32'(rsp_err), 32'(e.err));
            chk({e.nm, ".rdata"}, rsp_rdata,    e.rdata);
         end
      end else begin
         chk("rdata_idle", rsp_rdata, 32'd0);
      end
   end

   // One access; gnt_dly/rd_dly >= TO means the event never arrives.
   task automatic access(input string nm, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int gnt_dly, input int rd_dly, input logic [31:0] rdata,
                         input logic legal, input logic exp_err, input logic [31:0] exp_rd,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd);
      int   n;
      int   seen0;
      exp_t e;
      e.err = exp_err; e.rdata = exp_rd; e.nm = nm;
      exp_q.push_back(e);
      seen0 = rsp_seen;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      @(negedge clk);
      chk({nm, ".ready"},  32'(req_ready), 32'd1);
      chk({nm, ".stall0"}, 32'(stall), 32'(legal));
      chk({nm, ".req0"},   32'(mem_if.mem_req), 32'd0);
      @(posedge clk); #1;
      if (legal) begin
         n = (gnt_dly >= TO) ? TO : gnt_dly + 1;
         for (int i = 0; i < n; i++) begin
            if (i == gnt_dly) begin
               mem_if.mem_gnt = 1'b1;
               // rvalid with the grant must be ignored
               if (!we) begin mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'hFFFF_FFFF; end
            end
            @(negedge clk);
            if (i == 0) begin
               chk({nm, ".addr"}, 32'(mem_if.mem_addr), addr >> 2);
               chk({nm, ".be"},   32'(mem_if.mem_be), 32'(exp_be));
               chk({nm, ".we"},   32'(mem_if.mem_we), 32'(we));
               if (we) chk({nm, ".wdata"}, mem_if.mem_wdata, exp_wd);
            end
            if (i == n - 1) begin
               chk({nm, ".req"},   32'(mem_if.mem_req), 32'd1);
               chk({nm, ".stall"}, 32'(stall), 32'd1);
            end
            @(posedge clk); #1;
            mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0;
         end
         if (!we && gnt_dly < TO) begin
            n = (rd_dly >= TO) ? TO : rd_dly + 1;
            for (int i = 0; i < n; i++) begin
               if (i == rd_dly) begin mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = rdata; end
               @(negedge clk);
               if (i == 0) chk({nm, ".rd_req"}, 32'(mem_if.mem_req), 32'd0);
               @(posedge clk); #1;
               mem_if.mem_rvalid = 1'b0;
            end
         end
      end
      // response cycle
      @(negedge clk);
      chk({nm, ".rsp_stall"}, 32'(stall), 32'd0);
      chk({nm, ".rsp_req"},   32'(mem_if.mem_req), 32'd0);
      if (!we && !exp_err) begin
         ref_rdata = rdata; ref_off = addr[1:0]; ref_f3 = f3;
         #1 chk({nm, ".align"}, ref_data, exp_rd);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk({nm, ".nrsp"}, 32'(rsp_seen - seen0), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int seen0;
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
      req_addr = 32'b0; req_wdata = 32'b0;
      ref_rdata = 32'b0; ref_off = 2'b0; ref_f3 = 3'b0;
      mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 32'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.ready", 32'(req_ready), 32'd1);
      chk("rst.stall", 32'(stall), 32'd0);
      chk("rst.rsp",   32'(rsp_valid), 32'd0);
      chk("rst.err",   32'(rsp_err), 32'd0);
      chk("rst.req",   32'(mem_if.mem_req), 32'd0);
      chk("rst.we",    32'(mem_if.mem_we), 32'd0);
      chk("rst.be",    32'(mem_if.mem_be), 32'd0);
      chk("rst.addr",  32'(mem_if.mem_addr), 32'd0);
      chk("rst.wdata", mem_if.mem_wdata, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      //     name      we    f3     addr          wdata          gnt rd  rdata          legal err  exp_rdata      be       wdata
      access("sw",     1'b1, F3_W,  32'h0000_0104, 32'hDEAD_BEEF, 1,  0,  32'h0,         1'b1, 1'b0, 32'h0,         4'b1111, 32'hDEAD_BEEF);
      access("lb",     1'b0, F3_B,  32'h0000_0103, 32'h0,         0,  0,  32'h80AA_55CC, 1'b1, 1'b0, 32'hFFFF_FF80, 4'b1000, 32'h0);
      access("lbu",    1'b0, F3_BU, 32'h0000_0103, 32'h0,         0,  1,  32'h80AA_55CC, 1'b1, 1'b0, 32'h0000_0080, 4'b1000, 32'h0);
      access("lh",     1'b0, F3_H,  32'h0000_0202, 32'h0,         2,  0,  32'h8001_1234, 1'b1, 1'b0, 32'hFFFF_8001, 4'b1100, 32'h0);
      access("lhu",    1'b0, F3_HU, 32'h0000_0202, 32'h0,         0,  0,  32'h8001_1234, 1'b1, 1'b0, 32'h0000_8001, 4'b1100, 32'h0);
      access("lw_mis", 1'b0, F3_W,  32'h0000_0102, 32'h0,         0,  0,  32'h0,         1'b0, 1'b1, 32'h0,         4'b0000, 32'h0);
      access("gnt_to", 1'b0, F3_W,  32'h0000_0300, 32'h0,         99, 0,  32'h0,         1'b1, 1'b1, 32'h0,         4'b1111, 32'h0);
      access("gnt_ex", 1'b0, F3_W,  32'h0000_0300, 32'h0,         15, 2,  32'h1234_5678, 1'b1, 1'b0, 32'h1234_5678, 4'b1111, 32'h0);
      access("rd_to",  1'b0, F3_W,  32'h0000_0010, 32'h0,         0,  99, 32'h0,         1'b1, 1'b1, 32'h0,         4'b1111, 32'h0);
      access("rd_ex",  1'b0, F3_W,  32'h0000_0014, 32'h0,         0,  15, 32'hCAFE_F00D, 1'b1, 1'b0, 32'hCAFE_F00D, 4'b1111, 32'h0);
      access("sb",     1'b1, F3_B,  32'h0000_0101, 32'h0000_00A5, 0,  0,  32'h0,         1'b1, 1'b0, 32'h0,         4'b0010, 32'hA5A5_A5A5);
      access("sh",     1'b1, F3_H,  32'h0000_0006, 32'h1234_BEEF, 3,  0,  32'h0,         1'b1, 1'b0, 32'h0,         4'b1100, 32'hBEEF_BEEF);
      access("f3_011", 1'b0, 3'b011,32'h0000_0000, 32'h0,         0,  0,  32'h0,         1'b0, 1'b1, 32'h0,         4'b0000, 32'h0);
      access("sbu",    1'b1, F3_BU, 32'h0000_0000, 32'h0,         0,  0,  32'h0,         1'b0, 1'b1, 32'h0,         4'b0000, 32'h0);
      access("lh_mis", 1'b0, F3_H,  32'h0000_0201, 32'h0,         0,  0,  32'h0,         1'b0, 1'b1, 32'h0,         4'b0000, 32'h0);
      access("lb_pos", 1'b0, F3_B,  32'h0000_0100, 32'h0,         0,  0,  32'h0000_007F, 1'b1, 1'b0, 32'h0000_007F, 4'b0001, 32'h0);
      access("lb_o1",  1'b0, F3_B,  32'h0000_0101, 32'h0,         0,  0,  32'h0000_9A00, 1'b1, 1'b0, 32'hFFFF_FF9A, 4'b0010, 32'h0);
      access("lh_o0",  1'b0, F3_H,  32'h0000_0200, 32'h0,         0,  0,  32'hFFFF_7FFE, 1'b1, 1'b0, 32'h0000_7FFE, 4'b0011, 32'h0);

      // reset while waiting for read data: nothing may be reported
      seen0 = rsp_seen;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h0000_0400;
      @(posedge clk); #1;
      mem_if.mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_if.mem_gnt = 1'b0; req_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1; mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h5555_AAAA;
      @(negedge clk);
      chk("mrst.ready", 32'(req_ready), 32'd1);
      chk("mrst.stall", 32'(stall), 32'd0);
      chk("mrst.req",   32'(mem_if.mem_req), 32'd0);
      @(posedge clk); #1;
      mem_if.mem_rvalid = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk("mrst.nrsp", 32'(rsp_seen - seen0), 32'd0);

      chk("drain", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
